// File: rtl/pipe_ctrl.sv
// Pipeline control for the five-stage MIPS core: stall prioritisation, exception/eret/bus-timeout
// redirect sequencing with a one-cycle flush pulse, and a saturating stall-cycle counter.
module pipe_ctrl #(
   parameter logic [31:0] EXC_VECTOR  = 32'h8000_0180,
   parameter int          MEM_TIMEOUT = 16,
   parameter int          HOLDOFF     = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic        excp_valid,
   input  logic [4:0]  excp_code,
   input  logic [31:0] mem_pc,
   input  logic        eret_valid,
   input  logic [31:0] cp0_epc,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic        excp_commit,
   output logic [31:0] epc_o,
   output logic [4:0]  excp_code_o,
   output logic [31:0] stall_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);
   localparam logic [3:0]  HOLD_LD  = 4'(HOLDOFF);
   localparam logic [4:0]  EXC_DBE  = 5'h07;

   state_t      state_q, state_d;
   logic [15:0] tmo_cnt_q, tmo_cnt_d;
   logic [3:0]  hold_cnt_q, hold_cnt_d;
   logic        flush_q, flush_d;
   logic [31:0] new_pc_q, new_pc_d;
   logic        excp_commit_q, excp_commit_d;
   logic [31:0] epc_q, epc_d;
   logic [4:0]  excp_code_q, excp_code_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   logic        is_idle;
   logic        tmo_hit;
   logic        trig;
   logic [5:0]  req_stall;

   // Trigger detection and stall mapping; triggers only count in IDLE.
   always_comb begin
      is_idle = (state_q == IDLE);
      tmo_hit = is_idle && stallreq_mem && (tmo_cnt_q == TMO_LAST);
      trig    = is_idle && (excp_valid || tmo_hit || eret_valid);

      req_stall = 6'b000000;
      if (stallreq_mem)     req_stall = 6'b011111;
      else if (stallreq_ex) req_stall = 6'b001111;
      else if (stallreq_id) req_stall = 6'b000111;

      stall = req_stall;
      if (rst)                 stall = 6'b000000;
      else if (state_q == FLUSH) stall = 6'b000000;
      else if (trig)           stall = 6'b111111;
   end

   always_comb begin
      state_d       = state_q;
      tmo_cnt_d     = 16'd0;
      hold_cnt_d    = hold_cnt_q;
      flush_d       = 1'b0;
      excp_commit_d = 1'b0;
      new_pc_d      = new_pc_q;
      epc_d         = epc_q;
      excp_code_d   = excp_code_q;

      case (state_q)
         IDLE: begin
            if (trig) begin
               state_d = FLUSH;
               flush_d = 1'b1;
               if (excp_valid || tmo_hit) begin
                  new_pc_d      = EXC_VECTOR;
                  epc_d         = mem_pc;
                  excp_code_d   = excp_valid ? excp_code : EXC_DBE;
                  excp_commit_d = 1'b1;
               end else begin
                  new_pc_d = cp0_epc;
               end
            end else if (stallreq_mem) begin
               tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
         end
         FLUSH: begin
            state_d    = HOLD;
            hold_cnt_d = HOLD_LD;
         end
         HOLD: begin
            hold_cnt_d = hold_cnt_q - 4'd1;
            if (hold_cnt_q <= 4'd1) begin
               state_d    = IDLE;
               hold_cnt_d = 4'd0;
            end
         end
         default: state_d = IDLE;
      endcase

      stall_cnt_d = stall_cnt_q;
      if (stall[0] && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         tmo_cnt_q     <= 16'd0;
         hold_cnt_q    <= 4'd0;
         flush_q       <= 1'b0;
         new_pc_q      <= 32'd0;
         excp_commit_q <= 1'b0;
         epc_q         <= 32'd0;
         excp_code_q   <= 5'd0;
         stall_cnt_q   <= 32'd0;
      end else begin
         state_q       <= state_d;
         tmo_cnt_q     <= tmo_cnt_d;
         hold_cnt_q    <= hold_cnt_d;
         flush_q       <= flush_d;
         new_pc_q      <= new_pc_d;
         excp_commit_q <= excp_commit_d;
         epc_q         <= epc_d;
         excp_code_q   <= excp_code_d;
         stall_cnt_q   <= stall_cnt_d;
      end
   end

   assign flush       = flush_q;
   assign new_pc      = new_pc_q;
   assign excp_commit = excp_commit_q;
   assign epc_o       = epc_q;
   assign excp_code_o = excp_code_q;
   assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl: each cycle's expected outputs are queued by the
// driver and compared by an independent negedge monitor.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
   logic        excp_valid = 1'b0, eret_valid = 1'b0;
   logic [4:0]  excp_code = 5'd0;
   logic [31:0] mem_pc = 32'd0, cp0_epc = 32'd0;
   logic [5:0]  stall;
   logic        flush, excp_commit;
   logic [31:0] new_pc, epc_o, stall_cnt;
   logic [4:0]  excp_code_o;

   localparam logic [31:0] VEC = 32'h8000_0180;
   localparam logic [1:0]  S_IDLE = 2'd0, S_FLUSH = 2'd1, S_HOLD = 2'd2;

   pipe_ctrl dut (
      .clk(clk), .rst(rst),
      .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
      .excp_valid(excp_valid), .excp_code(excp_code), .mem_pc(mem_pc),
      .eret_valid(eret_valid), .cp0_epc(cp0_epc),
      .stall(stall), .flush(flush), .new_pc(new_pc), .excp_commit(excp_commit),
      .epc_o(epc_o), .excp_code_o(excp_code_o), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]  id;
      logic [1:0]  st;
      logic [5:0]  stall;
      logic        flush;
      logic        commit;
      logic        chk_regs;
      logic [31:0] npc;
      logic [31:0] epc;
      logic [4:0]  code;
      logic [31:0] cnt;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_pass = 0;
   logic [31:0] e_cnt = 32'd0;
   logic [7:0]  vec_id = 8'd0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Queue the outputs expected at this cycle's negedge; stall_cnt lags stall by one cycle.
   task automatic expect_out(input logic [1:0] st, input logic [5:0] s, input logic f, input logic c,
                             input logic chk, input logic [31:0] npc, input logic [31:0] epc,
                             input logic [4:0] code);
      exp_t e;
      if (rst) e_cnt = 32'd0;
      e.id = vec_id; e.st = st; e.stall = s; e.flush = f; e.commit = c; e.chk_regs = chk;
      e.npc = npc; e.epc = epc; e.code = code; e.cnt = e_cnt;
      exp_q.push_back(e);
      if (s[0]) e_cnt = e_cnt + 32'd1;
      vec_id = vec_id + 8'd1;
   endtask

   task automatic check(input logic [7:0] id, input string name, input logic [31:0] act,
                        input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL vec %0d %s: got 0x%0h want 0x%0h", id, name, act, req);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check(e.id, "state", 32'(dut.state_q), 32'(e.st));
         check(e.id, "stall", 32'(stall), 32'(e.stall));
         check(e.id, "flush", 32'(flush), 32'(e.flush));
         check(e.id, "excp_commit", 32'(excp_commit), 32'(e.commit));
         check(e.id, "stall_cnt", stall_cnt, e.cnt);
         if (e.chk_regs) begin
            check(e.id, "new_pc", new_pc, e.npc);
            check(e.id, "epc_o", epc_o, e.epc);
            check(e.id, "excp_code_o", 32'(excp_code_o), 32'(e.code));
         end
      end
   end

   task automatic idle_cycle();
      tick();
      expect_out(S_IDLE, 6'b000000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
   endtask

   initial begin
      // Reset: stall gated to zero even with a pending request.
      tick();
      stallreq_id = 1'b1;
      expect_out(S_IDLE, 6'b000000, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 5'd0);

      // Stall priority
      tick(); rst = 1'b0;
      expect_out(S_IDLE, 6'b000111, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      tick(); stallreq_ex = 1'b1;
      expect_out(S_IDLE, 6'b001111, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      tick(); stallreq_mem = 1'b1;
      expect_out(S_IDLE, 6'b011111, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      tick(); stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0;
      expect_out(S_IDLE, 6'b000000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);  // stall_cnt = 3

      // Exception
      tick(); excp_valid = 1'b1; excp_code = 5'h0C; mem_pc = 32'h0040_0010;
      expect_out(S_IDLE, 6'b111111, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      tick(); excp_valid = 1'b0;
      expect_out(S_FLUSH, 6'b000000, 1'b1, 1'b1, 1'b1, VEC, 32'h0040_0010, 5'h0C);
      tick(); excp_valid = 1'b1; excp_code = 5'h04; stallreq_id = 1'b1;
      expect_out(S_HOLD, 6'b000111, 1'b0, 1'b0, 1'b1, VEC, 32'h0040_0010, 5'h0C);
      tick(); excp_valid = 1'b0; stallreq_id = 1'b0;
      expect_out(S_IDLE, 6'b000000, 1'b0, 1'b0, 1'b1, VEC, 32'h0040_0010, 5'h0C);

      // Eret: EPC/Cause registers left untouched
      tick(); eret_valid = 1'b1; cp0_epc = 32'h0040_0014;
      expect_out(S_IDLE, 6'b111111, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      tick(); eret_valid = 1'b0;
      expect_out(S_FLUSH, 6'b000000, 1'b1, 1'b0, 1'b1, 32'h0040_0014, 32'h0040_0010, 5'h0C);
      tick();
      expect_out(S_HOLD, 6'b000000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      idle_cycle();

      // Simultaneous exception + eret + EX stall request
      tick(); excp_valid = 1'b1; excp_code = 5'h04; mem_pc = 32'h0040_0020;
      eret_valid = 1'b1; cp0_epc = 32'h1111_1110; stallreq_ex = 1'b1;
      expect_out(S_IDLE, 6'b111111, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      tick(); excp_valid = 1'b0; eret_valid = 1'b0; stallreq_ex = 1'b0;
      expect_out(S_FLUSH, 6'b000000, 1'b1, 1'b1, 1'b1, VEC, 32'h0040_0020, 5'h04);
      tick();
      expect_out(S_HOLD, 6'b000000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      idle_cycle();

      // 15-cycle MEM burst must not time out
      for (int i = 0; i < 15; i++) begin
         tick(); stallreq_mem = 1'b1;
         expect_out(S_IDLE, 6'b011111, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      end
      tick(); stallreq_mem = 1'b0;
      expect_out(S_IDLE, 6'b000000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      idle_cycle();

      // Bus timeout on the 16th consecutive cycle
      mem_pc = 32'h0040_0030;
      for (int i = 0; i < 15; i++) begin
         tick(); stallreq_mem = 1'b1;
         expect_out(S_IDLE, 6'b011111, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      end
      tick();
      expect_out(S_IDLE, 6'b111111, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      tick();
      expect_out(S_FLUSH, 6'b000000, 1'b1, 1'b1, 1'b1, VEC, 32'h0040_0030, 5'h07);
      tick();
      expect_out(S_HOLD, 6'b011111, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      tick();
      expect_out(S_IDLE, 6'b011111, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      tick(); stallreq_mem = 1'b0;
      expect_out(S_IDLE, 6'b000000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);

      // Reset in the FLUSH cycle
      tick(); excp_valid = 1'b1; excp_code = 5'h0D; mem_pc = 32'h0040_0040;
      expect_out(S_IDLE, 6'b111111, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      tick(); excp_valid = 1'b0; rst = 1'b1;
      expect_out(S_IDLE, 6'b000000, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 5'd0);
      tick(); rst = 1'b0;
      expect_out(S_IDLE, 6'b000000, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 5'd0);
      tick();
      expect_out(S_IDLE, 6'b000000, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 5'd0);

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: got %0d entries left want 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage MIPS core. It prioritises per-stage stall requests into the six-bit `stall` vector used by the PC register and the stage latches. It sequences exception entry, `eret` return and memory-bus timeout recovery. It produces a one-cycle `flush` pulse with the redirect address `new_pc`, and it keeps a saturating stall-cycle counter for performance measurement.

## Interface
- `EXC_VECTOR`, 32'h8000_0180, redirect target for exceptions and bus timeouts.
- `MEM_TIMEOUT`, 16, number of consecutive `stallreq_mem` cycles that raises a bus error; legal range 2..65535.
- `HOLDOFF`, 1, number of cycles after a flush during which triggers are ignored; legal range 1..15.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `stallreq_id` in 1: ID stage requests a stall (load-use).
- `stallreq_ex` in 1: EX stage requests a stall (multi-cycle mul/div).
- `stallreq_mem` in 1: MEM stage is waiting on the data bus.
- `excp_valid` in 1: MEM stage reports an exception this cycle.
- `excp_code` in 5: CP0 ExcCode of the reported exception.
- `mem_pc` in 32: PC of the instruction in MEM.
- `eret_valid` in 1: MEM stage holds an `eret`.
- `cp0_epc` in 32: current CP0 EPC value.
- `stall` out 6: bit 0 = PC, bits 1..5 = IF/ID/EX/MEM/WB latches; 1 = hold.
- `flush` out 1: registered one-cycle pulse that clears all stage latches and loads `new_pc` into the PC.
- `new_pc` out 32: registered redirect address; valid while `flush` = 1.
- `excp_commit` out 1: registered pulse coincident with `flush`; write strobe to CP0 for EPC/Cause.
- `epc_o` out 32: EPC value to write; valid while `excp_commit` = 1.
- `excp_code_o` out 5: Cause.ExcCode to write; valid while `excp_commit` = 1.
- `stall_cnt` out 32: count of cycles with `stall[0]` = 1; saturates at 32'hFFFF_FFFF.

## Operation
- FSM states: IDLE, FLUSH, HOLD.
- Trigger in IDLE, evaluated in priority order:
  - `excp_valid`;
  - else `tmo_hit`, defined as `stallreq_mem` = 1 while the timeout counter = MEM_TIMEOUT-1;
  - else `eret_valid`.
- Stall mapping (combinational):
  - IDLE with a trigger: 6'b111111.
  - Otherwise, in IDLE or HOLD: `stallreq_mem` → 6'b011111; else `stallreq_ex` → 6'b001111; else `stallreq_id` → 6'b000111; else 6'b000000.
  - FLUSH: 6'b000000.
- IDLE with a trigger → FLUSH. The registered outputs loaded for the FLUSH cycle depend on the trigger:
  - `excp_valid`: `new_pc` = EXC_VECTOR, `epc_o` = `mem_pc`, `excp_code_o` = `excp_code`, `excp_commit` = 1.
  - `tmo_hit`: same as `excp_valid`, except `excp_code_o` = 5'h07 (DBE).
  - `eret_valid`: `new_pc` = `cp0_epc`, `excp_commit` = 0, `epc_o` and `excp_code_o` unchanged.
- FLUSH → HOLD unconditionally. `flush` and `excp_commit` return to 0. The hold counter loads HOLDOFF.
- HOLD: decrement the hold counter each cycle; go to IDLE after the cycle in which it reaches 1. Triggers in HOLD are ignored, but stall requests are honoured.
- Timeout counter (16 bits):
  - In IDLE: increments while `stallreq_mem` = 1; clears when `stallreq_mem` = 0.
  - Outside IDLE, or on any trigger: forced to 0.
- `stall_cnt` increments on every cycle with `stall[0]` = 1, including trigger cycles. It holds at all-ones once saturated.

## Timing
- Reset values (asynchronous): state IDLE, `flush` 0, `new_pc` 0, `excp_commit` 0, `epc_o` 0, `excp_code_o` 0, `stall_cnt` 0, both counters 0. `stall` is 0 while `rst` is high.
- Trigger latency:
  - Trigger sampled in cycle N: `stall` = 6'b111111 in cycle N.
  - `flush`/`new_pc` valid in cycle N+1, with `stall` = 0.
  - The PC loads `new_pc` at the end of N+1.
  - Triggers are accepted again from cycle N+2+HOLDOFF.
- Simultaneous events:
  - `excp_valid` + `eret_valid`: the exception wins.
  - `excp_valid` + `tmo_hit`: `excp_code` wins.
  - Stall requests concurrent with a trigger are overridden by 6'b111111.
- Reset asserted mid-FLUSH or mid-HOLD: all outputs return to reset values immediately; `flush` must not pulse after `rst` deasserts.
- `tmo_hit` fires on the MEM_TIMEOUT-th consecutive `stallreq_mem` cycle.

## Test plan
- Stall priority: `stallreq_id`=1 → `stall`=6'b000111. Add `stallreq_ex` → 6'b001111. Add `stallreq_mem` → 6'b011111. `stall_cnt` = 3 after the three cycles.
- Exception: `excp_valid`=1, `excp_code`=5'h0C, `mem_pc`=32'h0040_0010 in cycle N. Required response:
  - Cycle N: `stall`=6'b111111.
  - Cycle N+1: `flush`=1, `excp_commit`=1, `new_pc`=32'h8000_0180, `epc_o`=32'h0040_0010, `excp_code_o`=5'h0C.
  - `excp_valid` pulsed in cycle N+2: ignored.
- Eret: `eret_valid`=1, `cp0_epc`=32'h0040_0014 → next cycle `flush`=1, `new_pc`=32'h0040_0014, `excp_commit`=0.
- Bus timeout: hold `stallreq_mem`=1. Cycles 1..15 give `stall`=6'b011111. Cycle 16 gives 6'b111111. Cycle 17 gives `flush`=1, `excp_code_o`=5'h07. A 15-cycle burst followed by a release must not fire.
- Simultaneous: `excp_valid` and `eret_valid` in the same cycle → `new_pc`=EXC_VECTOR, `excp_commit`=1.
- Reset mid-sequence: assert `rst` in the FLUSH cycle → `flush`=0 at once, state IDLE, `stall_cnt`=0, no pulse after release.
